// File: rtl/ab_log_pkg.sv
// Shared types for the A/B enforcement event logger: recovery-ref width, FSM states, event record.
package ab_log_pkg;
  localparam int REF_W = 3;
  localparam logic [REF_W-1:0] REF_NONE = '0;

  typedef enum logic {RUN, HOLD} log_state_e;

  typedef struct packed {
    logic [7:0]       stamp;
    logic [REF_W-1:0] ref_b;
    logic [REF_W-1:0] ref_a;
    logic             edit_b;
    logic             edit_a;
  } ab_evt_t;
endpackage

// File: rtl/ab_log_fifo.sv
// Show-ahead FIFO; push and pop in the same cycle are legal at both full and empty.
module ab_log_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    pop_ok, push_ok;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A pop frees the slot the push needs when full
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  end
endmodule

// File: rtl/ab_enforcement_event_logger.sv
// Registers final A/B ctp outputs, logs recovery/edit events into a FIFO, counts recoveries.
// Optional ABLOG_STAMP_EN: builds the 8-bit cycle stamp and stores it in each record.
module ab_enforcement_event_logger
  import ab_log_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16,
  parameter int REF_W      = ab_log_pkg::REF_W,
  parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A_ctp_in,
  input  logic             B_ctp_in,
  input  logic             A_ctp_out,
  input  logic             B_ctp_out,
  input  logic [REF_W-1:0] policy_a_recovery_ref,
  input  logic [REF_W-1:0] policy_b_recovery_ref,
  output logic             A_ctp_q,
  output logic             B_ctp_q,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [15:0]      evt_data,
  output logic [LW-1:0]    fifo_level,
  output logic [CNT_W-1:0] rec_count_a,
  output logic [CNT_W-1:0] rec_count_b,
  output logic             overflow,
  input  logic             clr
);
`ifdef ABLOG_STAMP_EN
  localparam int FW = 16;
  logic [7:0] stamp_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stamp_q <= '0;
    else        stamp_q <= stamp_q + 8'd1;
  end
`else
  localparam int FW = 8;
  logic [7:0] stamp_q;
  assign stamp_q = 8'h00;
`endif

  ab_evt_t    evt;
  log_state_e state, state_nx;
  logic       ev, pop, push_req, drop, full, empty;
  logic [FW-1:0] fifo_dout;
  logic [1:0][REF_W-1:0] refs;
  logic [1:0][CNT_W-1:0] rec_cnt;

  assign refs       = {policy_b_recovery_ref, policy_a_recovery_ref};
  assign evt.stamp  = stamp_q;
  assign evt.ref_b  = policy_b_recovery_ref;
  assign evt.ref_a  = policy_a_recovery_ref;
  assign evt.edit_b = B_ctp_in ^ B_ctp_out;
  assign evt.edit_a = A_ctp_in ^ A_ctp_out;

  assign ev       = evt.edit_a | evt.edit_b | (evt.ref_a != REF_NONE) | (evt.ref_b != REF_NONE);
  assign evt_valid = ~empty;
  assign pop      = evt_valid & evt_ready;
  assign push_req = ev & (state == RUN);
  assign drop     = push_req & full & ~pop;

  ab_log_fifo #(.W(FW), .DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req & ~drop),
    .din   (evt[FW-1:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

`ifdef ABLOG_STAMP_EN
  assign evt_data = fifo_dout;
`else
  assign evt_data = {8'h00, fifo_dout};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (drop) state_nx = HOLD;
      HOLD:    state_nx = HOLD;
      default: state_nx = RUN;
    endcase
    if (clr) state_nx = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      A_ctp_q  <= 1'b0;
      B_ctp_q  <= 1'b0;
    end else begin
      A_ctp_q <= A_ctp_out;
      B_ctp_q <= B_ctp_out;
      if (clr)       overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

  // One saturating recovery counter per policy
  for (genvar g = 0; g < 2; g++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  rec_cnt[g] <= '0;
      else if (clr)                                rec_cnt[g] <= '0;
      else if (refs[g] != REF_NONE && ~&rec_cnt[g]) rec_cnt[g] <= rec_cnt[g] + CNT_W'(1);
    end
  end

  assign rec_count_a = rec_cnt[0];
  assign rec_count_b = rec_cnt[1];
endmodule
